// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared sizes, state encoding and defaults for the round-robin arbiter
package rr_arbiter8_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W = 3;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_GRANT = 1'b1;
  localparam int MAX_HOLD_DEF = 16;
endpackage

// File: rtl/decoder3b8.sv
// decoder3b8: 3-to-8 one-hot decoder
module decoder3b8 (
  input  logic [2:0] sel,
  output logic [7:0] dec
);
  assign dec = 8'b1 << sel;
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-requester round-robin arbiter with idle handoff cycle and optional hold timeout
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HOLD_W = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout
);
  logic state;
  logic [IDX_W-1:0] ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [NUM_REQ-1:0] dec;
  logic rel_drop;
  logic rel_to;
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] w;
    w = p;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (r[p + IDX_W'(i)]) w = p + IDX_W'(i);
    return w;
  endfunction
  assign rel_drop = !req[grant_idx];
  assign rel_to = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      grant_idx <= '0;
      grant_valid <= 1'b0;
      timeout <= 1'b0;
    end else if (state == ST_IDLE) begin
      timeout <= 1'b0;
      if (|req) begin
        state <= ST_GRANT;
        grant_idx <= rr_pick(req, ptr);
        grant_valid <= 1'b1;
        hold_cnt <= '0;
      end
    end else if (done || rel_drop || rel_to) begin
      state <= ST_IDLE;
      grant_valid <= 1'b0;
      ptr <= grant_idx + IDX_W'(1);
      timeout <= rel_to && !done && !rel_drop;
    end else begin
      hold_cnt <= &hold_cnt ? hold_cnt : hold_cnt + HOLD_W'(1);
    end
  end
  decoder3b8 u_dec (
    .sel(grant_idx),
    .dec(dec)
  );
  assign grant = dec & {NUM_REQ{grant_valid}};
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: scoreboard bench for rr_arbiter8 built with a 4-cycle hold limit
module tb_rr_arbiter8;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [7:0] req = '0;
  logic done = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic grant_valid;
  logic timeout;
  logic [12:0] got;
  logic [12:0] sb[$];
  int tests = 0;
  int fails = 0;
  always #5 CLK = ~CLK;
  rr_arbiter8 #(.MAX_HOLD(4), .HOLD_W(3)) dut (
    .CLK(CLK),
    .RST(RST),
    .req(req),
    .done(done),
    .grant(grant),
    .grant_idx(grant_idx),
    .grant_valid(grant_valid),
    .timeout(timeout)
  );
  assign got = {grant, grant_idx, grant_valid, timeout};
  function automatic logic [12:0] ex(input int idx, input bit v, input bit to);
    logic [7:0] g;
    g = v ? 8'(1 << idx) : 8'h00;
    return {g, 3'(idx), v, to};
  endfunction
  task automatic step(input logic r_st, input logic [7:0] r, input logic d, input logic [12:0] e);
    RST = r_st;
    req = r;
    done = d;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset();
    RST = 1'b1;
    req = '0;
    done = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask
  task automatic test_reset();
    logic [12:0] e;
    step(1'b1, 8'hFF, 1'b1, ex(0, 0, 0));
    e = sb.pop_front();
    tests++;
    if (got !== e) begin fails++; $display("FAIL reset got=%h exp=%h", got, e); end
  endtask
  task automatic test_single();
    logic [7:0] rs[6];
    logic ds[6];
    logic [12:0] es[6];
    logic [12:0] e;
    rs = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00};
    ds = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    es = '{ex(2,1,0), ex(2,1,0), ex(2,1,0), ex(2,0,0), ex(2,1,0), ex(2,0,0)};
    for (int k = 0; k < 6; k++) begin
      step(1'b0, rs[k], ds[k], es[k]);
      e = sb.pop_front();
      tests++;
      if (got !== e) begin fails++; $display("FAIL single[%0d] got=%h exp=%h", k, got, e); end
    end
  endtask
  task automatic test_rotation();
    logic [12:0] e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      for (int s = 0; s < 3; s++) begin
        step(1'b0, 8'hFF, s == 2, ex(i % 8, s != 2, 0));
        e = sb.pop_front();
        tests++;
        if (got !== e) begin fails++; $display("FAIL rotation[%0d.%0d] got=%h exp=%h", i, s, got, e); end
      end
    end
  endtask
  task automatic test_timeout();
    logic [12:0] es[11];
    logic [12:0] e;
    es = '{ex(0,1,0), ex(0,1,0), ex(0,1,0), ex(0,1,0), ex(0,0,1),
           ex(7,1,0), ex(7,1,0), ex(7,1,0), ex(7,1,0), ex(7,0,1), ex(0,1,0)};
    do_reset();
    for (int k = 0; k < 11; k++) begin
      step(1'b0, 8'h81, 1'b0, es[k]);
      e = sb.pop_front();
      tests++;
      if (got !== e) begin fails++; $display("FAIL timeout[%0d] got=%h exp=%h", k, got, e); end
    end
  endtask
  task automatic test_coincident();
    logic ds[6];
    logic [12:0] es[6];
    logic [12:0] e;
    ds = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    es = '{ex(0,1,0), ex(0,1,0), ex(0,1,0), ex(0,1,0), ex(0,0,0), ex(7,1,0)};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 8'h81, ds[k], es[k]);
      e = sb.pop_front();
      tests++;
      if (got !== e) begin fails++; $display("FAIL coincident[%0d] got=%h exp=%h", k, got, e); end
    end
  endtask
  task automatic test_owner_drop();
    logic [7:0] rs[5];
    logic ds[5];
    logic [12:0] es[5];
    logic [12:0] e;
    rs = '{8'h08, 8'h08, 8'h01, 8'h09, 8'h09};
    ds = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    es = '{ex(3,1,0), ex(3,1,0), ex(3,0,0), ex(0,1,0), ex(0,0,0)};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b0, rs[k], ds[k], es[k]);
      e = sb.pop_front();
      tests++;
      if (got !== e) begin fails++; $display("FAIL owner_drop[%0d] got=%h exp=%h", k, got, e); end
    end
  endtask
  task automatic test_reset_mid();
    logic rst_s[4];
    logic [7:0] rs[4];
    logic [12:0] es[4];
    logic [12:0] e;
    rst_s = '{1'b0, 1'b0, 1'b1, 1'b0};
    rs = '{8'h20, 8'h20, 8'h20, 8'h22};
    es = '{ex(5,1,0), ex(5,1,0), ex(0,0,0), ex(1,1,0)};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(rst_s[k], rs[k], 1'b0, es[k]);
      e = sb.pop_front();
      tests++;
      if (got !== e) begin fails++; $display("FAIL reset_mid[%0d] got=%h exp=%h", k, got, e); end
    end
  endtask
  task automatic test_idle_done();
    logic [7:0] rs[4];
    logic ds[4];
    logic [12:0] es[4];
    logic [12:0] e;
    rs = '{8'h00, 8'h00, 8'h10, 8'h10};
    ds = '{1'b1, 1'b1, 1'b1, 1'b0};
    es = '{ex(0,0,0), ex(0,0,0), ex(4,1,0), ex(4,1,0)};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, rs[k], ds[k], es[k]);
      e = sb.pop_front();
      tests++;
      if (got !== e) begin fails++; $display("FAIL idle_done[%0d] got=%h exp=%h", k, got, e); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_coincident();
    test_owner_drop();
    test_reset_mid();
    test_idle_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
